// File: rtl/result_checker.sv
// Result checker: pairs each DUT result with an {mask, expected} word, compares
// under the mask, keeps saturating counters and logs one record per failing vector.
module result_checker #(
  parameter int RTF_WIDTH = 24,
  parameter int CNT_WIDTH = 16,
  parameter int EXF_WIDTH = 2*RTF_WIDTH,
  parameter int LOG_WIDTH = CNT_WIDTH + 2*RTF_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [RTF_WIDTH-1:0] rfifo_data,
  output logic                 rfifo_rdreq,
  input  logic                 rfifo_rdempty,
  input  logic [EXF_WIDTH-1:0] efifo_data,
  output logic                 efifo_rdreq,
  input  logic                 efifo_rdempty,
  output logic [LOG_WIDTH-1:0] lfifo_data,
  output logic                 lfifo_wrreq,
  input  logic                 lfifo_wrfull,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] vec_count,
  output logic [CNT_WIDTH-1:0] fail_count,
  output logic                 any_fail,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_CMP,
    S_LOG_WAIT
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_fail;
  logic [RTF_WIDTH-1:0] w_expected;
  logic [RTF_WIDTH-1:0] w_mask;

  logic [RTF_WIDTH-1:0] r_res;
  logic [RTF_WIDTH-1:0] r_mismatch;
  logic [CNT_WIDTH-1:0] r_index;
  logic [CNT_WIDTH-1:0] r_vec_count;
  logic [CNT_WIDTH-1:0] r_fail_count;
  logic                 r_any_fail;

  assign w_expected = efifo_data[RTF_WIDTH-1:0];
  assign w_mask     = efifo_data[2*RTF_WIDTH-1:RTF_WIDTH];
  assign w_fail     = (r_state == S_CMP) && (r_mismatch != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_push = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!rfifo_rdempty && !efifo_rdempty) begin
          w_pop  = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_FETCH: w_next = S_CMP;
      S_CMP: begin
        w_next = S_IDLE;
        if (w_fail) begin
          if (!lfifo_wrfull) begin
            w_push = 1'b1;
          end else begin
            w_next = S_LOG_WAIT;
          end
        end
      end
      S_LOG_WAIT: begin
        if (!lfifo_wrfull) begin
          w_push = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Clear and reset both abandon the current vector without touching any FIFO.
    if (clear || reset) begin
      w_next = S_IDLE;
      w_pop  = 1'b0;
      w_push = 1'b0;
    end
  end

  // The record is built while the response is fetched so lfifo_data is a pure
  // register and already stable in the CMP cycle that may push it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_res      <= '0;
      r_mismatch <= '0;
      r_index    <= '0;
    end else if (r_state == S_FETCH) begin
      r_res      <= rfifo_data;
      r_mismatch <= (rfifo_data ^ w_expected) & w_mask;
      r_index    <= r_vec_count;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_vec_count  <= '0;
      r_fail_count <= '0;
      r_any_fail   <= 1'b0;
    end else if (r_state == S_CMP) begin
      if (!(&r_vec_count)) begin
        r_vec_count <= r_vec_count + 1'b1;
      end
      if (w_fail) begin
        r_any_fail <= 1'b1;
        if (!(&r_fail_count)) begin
          r_fail_count <= r_fail_count + 1'b1;
        end
      end
    end
  end

  assign rfifo_rdreq = w_pop;
  assign efifo_rdreq = w_pop;
  assign lfifo_wrreq = w_push;
  assign lfifo_data  = {r_index, r_res, r_mismatch};
  assign vec_count   = r_vec_count;
  assign fail_count  = r_fail_count;
  assign any_fail    = r_any_fail;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker: behavioural FIFO models around a default
// instance and a CNT_WIDTH=4 instance that share the same FIFO contents.
module tb_result_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  logic        wrfull;
  logic        sel4;
  logic [23:0] rdata;
  logic [47:0] edata;
  logic        res_has;
  logic        exp_has;

  logic        rempty0, eempty0, rempty4, eempty4;
  logic        rdreq0, erdreq0, wrreq0, any0, busy0;
  logic        rdreq4, erdreq4, wrreq4, any4, busy4;
  logic [55:0] ldata0;
  logic [51:0] ldata4;
  logic [15:0] vec0, fail0;
  logic [3:0]  vec4, fail4;

  logic [23:0] res_q[$];
  logic [47:0] exp_q[$];
  logic [63:0] log_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;
  int n_push  = 0;
  int pair_err = 0;

  always #5 clock = ~clock;

  assign rempty0 = sel4 | ~res_has;
  assign eempty0 = sel4 | ~exp_has;
  assign rempty4 = ~sel4 | ~res_has;
  assign eempty4 = ~sel4 | ~exp_has;

  result_checker u_dut (
    .clock(clock), .reset(reset),
    .rfifo_data(rdata), .rfifo_rdreq(rdreq0), .rfifo_rdempty(rempty0),
    .efifo_data(edata), .efifo_rdreq(erdreq0), .efifo_rdempty(eempty0),
    .lfifo_data(ldata0), .lfifo_wrreq(wrreq0), .lfifo_wrfull(wrfull),
    .clear(clear), .vec_count(vec0), .fail_count(fail0),
    .any_fail(any0), .busy(busy0)
  );

  result_checker #(.CNT_WIDTH(4)) u_dut4 (
    .clock(clock), .reset(reset),
    .rfifo_data(rdata), .rfifo_rdreq(rdreq4), .rfifo_rdempty(rempty4),
    .efifo_data(edata), .efifo_rdreq(erdreq4), .efifo_rdempty(eempty4),
    .lfifo_data(ldata4), .lfifo_wrreq(wrreq4), .lfifo_wrfull(wrfull),
    .clear(clear), .vec_count(vec4), .fail_count(fail4),
    .any_fail(any4), .busy(busy4)
  );

  typedef struct {
    logic [23:0] res;
    logic [23:0] ex;
    logic [23:0] mask;
    logic        fail;
    logic [23:0] mism;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic upd();
    res_has = (res_q.size() != 0);
    exp_has = (exp_q.size() != 0);
  endtask

  task automatic push_vec(input logic [23:0] r, input logic [23:0] e, input logic [23:0] m);
    res_q.push_back(r);
    exp_q.push_back({m, e});
    upd();
  endtask

  // One clock: sample DUT requests away from the edge, then act on them after it.
  task automatic step();
    logic        pop, push;
    logic [63:0] rec;
    #1;
    pop  = sel4 ? rdreq4 : rdreq0;
    if ((sel4 ? erdreq4 : erdreq0) != pop) pair_err++;
    push = sel4 ? wrreq4 : wrreq0;
    rec  = sel4 ? 64'(ldata4) : 64'(ldata0);
    @(posedge clock);
    #1;
    if (pop) begin
      n_pops++;
      if (res_q.size() > 0) rdata = res_q.pop_front();
      if (exp_q.size() > 0) edata = exp_q.pop_front();
    end
    if (push) begin
      n_push++;
      log_q.push_back(rec);
    end
    upd();
    @(negedge clock);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  vec_t tbl[5];

  initial begin
    int p0, l0;
    logic [63:0] rec;

    tbl[0] = '{res: 24'h00A5A5, ex: 24'h00A5A5, mask: 24'hFFFFFF, fail: 1'b0, mism: 24'h000000};
    tbl[1] = '{res: 24'h0000F0, ex: 24'h00000F, mask: 24'h0000FF, fail: 1'b1, mism: 24'h0000FF};
    tbl[2] = '{res: 24'h123456, ex: 24'h000000, mask: 24'h000000, fail: 1'b0, mism: 24'h000000};
    tbl[3] = '{res: 24'hFFFFFF, ex: 24'h000000, mask: 24'h800001, fail: 1'b1, mism: 24'h800001};
    tbl[4] = '{res: 24'h123456, ex: 24'h123457, mask: 24'hFFFFFE, fail: 1'b0, mism: 24'h000000};

    reset = 1'b1; clear = 1'b0; wrfull = 1'b0; sel4 = 1'b0;
    rdata = '0; edata = '0;
    upd();
    @(negedge clock);
    steps(2);
    push_vec(24'h1, 24'h0, 24'h1);
    #1;
    check("reset_rdreq", 64'(rdreq0), 0);
    check("reset_vec", 64'(vec0), 0);
    check("reset_fail", 64'(fail0), 0);
    check("reset_any", 64'(any0), 0);
    check("reset_ldata", 64'(ldata0), 0);
    check("reset_wrreq", 64'(wrreq0), 0);
    check("reset_busy", 64'(busy0), 0);
    res_q.delete(); exp_q.delete(); upd();
    reset = 1'b0;
    step();

    // Single-vector table, counters cleared before each entry.
    foreach (tbl[i]) begin
      pulse_clear();
      l0 = log_q.size();
      push_vec(tbl[i].res, tbl[i].ex, tbl[i].mask);
      steps(3);
      check($sformatf("t%0d_vec", i), 64'(vec0), 1);
      check($sformatf("t%0d_failcnt", i), 64'(fail0), 64'(tbl[i].fail));
      check($sformatf("t%0d_any", i), 64'(any0), 64'(tbl[i].fail));
      check($sformatf("t%0d_logs", i), 64'(log_q.size() - l0), 64'(tbl[i].fail));
      if (tbl[i].fail && log_q.size() > l0)
        check($sformatf("t%0d_record", i), log_q[l0], {8'h0, 16'd0, tbl[i].res, tbl[i].mism});
    end

    // Throughput: three passing vectors back to back take 3 cycles each.
    pulse_clear();
    for (int i = 0; i < 3; i++) push_vec(24'(i), 24'(i), 24'hFFFFFF);
    steps(8);
    check("thru_vec_at8", 64'(vec0), 2);
    step();
    check("thru_vec_at9", 64'(vec0), 3);
    check("thru_idle", 64'(busy0), 0);

    // Log FIFO full for 10 cycles while a failing vector waits.
    pulse_clear();
    wrfull = 1'b1;
    push_vec(24'h00000F, 24'h0, 24'h00000F);
    push_vec(24'h000100, 24'h000100, 24'hFFFFFF);
    p0 = n_pops; l0 = log_q.size();
    steps(2);
    begin
      int not_busy = 0;
      for (int i = 0; i < 10; i++) begin
        if (!busy0) not_busy++;
        step();
      end
      check("full_busy_drop", 64'(not_busy), 0);
    end
    check("full_pops", 64'(n_pops - p0), 1);
    check("full_no_log", 64'(log_q.size() - l0), 0);
    wrfull = 1'b0;
    #1;
    check("full_wrreq_on_drop", 64'(wrreq0), 1);
    step();
    check("full_one_log", 64'(log_q.size() - l0), 1);
    if (log_q.size() > l0)
      check("full_record", log_q[l0], {8'h0, 16'd0, 24'h00000F, 24'h00000F});
    steps(3);
    check("full_vec", 64'(vec0), 2);
    check("full_failcnt", 64'(fail0), 1);
    check("full_logs_total", 64'(log_q.size() - l0), 1);

    // Only EXP_FIFO populated: nothing pops until results arrive.
    pulse_clear();
    p0 = n_pops;
    for (int i = 0; i < 5; i++) exp_q.push_back({24'hFFFFFF, 24'(i + 16)});
    upd();
    steps(10);
    check("oneside_pops", 64'(n_pops - p0), 0);
    check("oneside_vec", 64'(vec0), 0);
    for (int i = 0; i < 5; i++) res_q.push_back(24'(i + 16));
    upd();
    steps(15);
    check("fill_vec", 64'(vec0), 5);
    check("fill_pops", 64'(n_pops - p0), 5);
    check("fill_fails", 64'(fail0), 0);
    check("pair_err", 64'(pair_err), 0);

    // Reset while a failing vector sits in CMP.
    pulse_clear();
    l0 = log_q.size();
    push_vec(24'h00FF00, 24'h0, 24'hFFFFFF);
    steps(2);
    check("mid_ldata", 64'(ldata0), {8'h0, 16'd0, 24'h00FF00, 24'h00FF00});
    reset = 1'b1;
    #1;
    check("mid_rst_wrreq", 64'(wrreq0), 0);
    step();
    push_vec(24'h000777, 24'h000777, 24'hFFFFFF);
    #1;
    check("mid_rst_rdreq", 64'(rdreq0), 0);
    step();
    reset = 1'b0;
    check("mid_rst_vec", 64'(vec0), 0);
    check("mid_rst_ldata", 64'(ldata0), 0);
    check("mid_rst_busy", 64'(busy0), 0);
    steps(3);
    check("mid_rst_nolog", 64'(log_q.size() - l0), 0);
    check("mid_rst_drain", 64'(vec0), 1);

    // Saturation with 4-bit counters.
    sel4 = 1'b1;
    pulse_clear();
    log_q.delete();
    for (int i = 0; i < 20; i++) push_vec(24'(i + 1), 24'h0, 24'hFFFFFF);
    steps(62);
    check("sat_vec", 64'(vec4), 15);
    check("sat_fail", 64'(fail4), 15);
    check("sat_any", 64'(any4), 1);
    check("sat_logs", 64'(log_q.size()), 20);
    for (int i = 0; i < 20; i++) begin
      if (log_q.size() > i) begin
        rec = log_q[i];
        check($sformatf("sat_idx%0d", i), 64'(rec[51:48]), (i < 15) ? 64'(i) : 64'd15);
      end
    end

    // Clear while a failing vector is in CMP.
    push_vec(24'h0000AA, 24'h0, 24'hFFFFFF);
    steps(2);
    check("clr_in_cmp", 64'(busy4), 1);
    clear = 1'b1;
    #1;
    check("clr_wrreq", 64'(wrreq4), 0);
    step();
    clear = 1'b0;
    check("clr_vec", 64'(vec4), 0);
    check("clr_fail", 64'(fail4), 0);
    check("clr_any", 64'(any4), 0);
    check("clr_busy", 64'(busy4), 0);
    steps(3);
    check("clr_nolog", 64'(log_q.size()), 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
